// File: rtl/sense_slice_feeder.sv
// Splits the raw counter stream at THRESHOLD into a bounded, slice-tagged sensed
// stream and an outlier-residue FIFO for the outlier-tree builder.
module sense_slice_feeder #(
  parameter int unsigned NUM_COUNTER = 10,
  parameter int unsigned NUM_SLICE   = 2,
  parameter int unsigned THRESHOLD   = 255,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_Counter,
  output logic        Spa_Valid,
  output logic [31:0] Spa_Counter,
  output logic [7:0]  Spa_Row,
  output logic [7:0]  Spa_Slice,
  output logic        Spa_Last,
  output logic        Ovf_Valid,
  input  logic        Ovf_Ready,
  output logic [15:0] Ovf_Index,
  output logic [31:0] Ovf_Value,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0]   THR        = 32'(THRESHOLD);
  localparam logic [7:0]    LAST_ROW   = 8'(NUM_COUNTER - 1);
  localparam logic [7:0]    LAST_SLICE = 8'(NUM_SLICE - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    logic [15:0] index;
    logic [31:0] value;
  } ovf_entry_t;

  state_e        state_q;
  logic [7:0]    row_q, slice_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  ovf_entry_t    mem_q [FIFO_DEPTH];
  ovf_entry_t    push_entry;
  ovf_entry_t    head;

  logic        in_ready_q, busy_q, done_q, ovf_valid_q;
  logic        spa_valid_q, spa_last_q;
  logic [31:0] spa_counter_q;
  logic [7:0]  spa_row_q, spa_slice_q;

  logic accept, over, push, pop, run_end;

  // Handshake decode and FIFO occupancy next-state
  always_comb begin
    accept  = In_Valid && in_ready_q;
    over    = In_Counter > THR;
    push    = accept && over;
    pop     = Ovf_Ready && (count_q != '0);
    run_end = accept && (row_q == LAST_ROW) && (slice_q == LAST_SLICE);
    push_entry.index = (16'(slice_q) * 16'(NUM_COUNTER)) + 16'(row_q);
    push_entry.value = In_Counter - THR;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    head = mem_q[rd_ptr_q];
  end

  // Run-control FSM; In_Ready is precomputed from next occupancy so it stays registered
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            in_ready_q <= (count_d != FULL_CNT);
          end
        end
        ST_RUN: begin
          if (run_end) begin
            state_q    <= ST_DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= (count_d != FULL_CNT);
          end
        end
        ST_DRAIN: begin
          if (count_d == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Row/slice tagging and the registered sensed stream
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_q         <= '0;
      slice_q       <= '0;
      spa_valid_q   <= 1'b0;
      spa_counter_q <= '0;
      spa_row_q     <= '0;
      spa_slice_q   <= '0;
      spa_last_q    <= 1'b0;
    end else begin
      spa_valid_q <= accept;
      if ((state_q == ST_IDLE) && Start) begin
        row_q   <= '0;
        slice_q <= '0;
      end else if (accept) begin
        if (row_q == LAST_ROW) begin
          row_q   <= '0;
          slice_q <= slice_q + 8'd1;
        end else begin
          row_q <= row_q + 8'd1;
        end
      end
      if (accept) begin
        spa_counter_q <= over ? THR : In_Counter;
        spa_row_q     <= row_q;
        spa_slice_q   <= slice_q;
        spa_last_q    <= (row_q == LAST_ROW);
      end
    end
  end

  // Outlier FIFO pointers and occupancy
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      ovf_valid_q <= (count_d != '0);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign In_Ready    = in_ready_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Spa_Valid   = spa_valid_q;
  assign Spa_Counter = spa_counter_q;
  assign Spa_Row     = spa_row_q;
  assign Spa_Slice   = spa_slice_q;
  assign Spa_Last    = spa_last_q;
  assign Ovf_Valid   = ovf_valid_q;
  // Head is masked while empty so the storage never leaks onto the port
  assign Ovf_Index   = ovf_valid_q ? head.index : 16'd0;
  assign Ovf_Value   = ovf_valid_q ? head.value : 32'd0;

endmodule
